// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port instruction/data memory between fetch (I) and load/store (D).
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is D priority with an I anti-starvation count.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_adr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic OwnI = 1'b0;
    localparam logic OwnD = 1'b1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              grant_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_q, rr_last_d;

    // On a tie, the requester not granted last goes next.
    always_comb begin
        grant_i = i_req && (!d_req || (rr_last_q == OwnD));
    end
`else
    localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;

    // D wins ties until I has lost MAX_WAIT ties in a row.
    always_comb begin
        grant_i = i_req && (!d_req || (wait_cnt_q >= MaxWaitC));
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_d   = rr_last_q;
`else
        wait_cnt_d  = wait_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    owner_d     = grant_i ? OwnI : OwnD;
                    adr_d       = grant_i ? i_adr : d_adr;
                    we_d        = !grant_i && d_we;
                    wdata_d     = grant_i ? wdata_q : d_wdata;
                    mem_read_d  = !we_d;
                    mem_write_d = we_d;
                    state_d     = StAccess;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_last_d   = owner_d;
`else
                    if (grant_i) begin
                        wait_cnt_d = 4'd0;
                    end else if (i_req && wait_cnt_q != 4'hF) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
`endif
                end
            end
            StAccess: begin
                if (!we_q) begin
                    if (owner_q == OwnD) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                end
                i_ack_d = (owner_q == OwnI);
                d_ack_d = (owner_q == OwnD);
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Async reset drops mem_write at once, so an interrupted write never commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnI;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q   <= OwnD;
`else
            wait_cnt_q  <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q   <= rr_last_d;
`else
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, arbitration/reset sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_adr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_adr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] mem_adr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_adr    (i_adr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_adr    (d_adr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_adr  (mem_adr),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, posedge write, 256 words.
    logic [31:0] mem [0:255];
    logic        init_req = 1'b0;
    int          init_seed = 0;

    function automatic logic [31:0] mem_pat(input int idx, input int seed);
        if (seed == 0) return (idx == 2) ? 32'h8C220004 : 32'h0;
        return (32'(idx) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= mem_pat(k, init_seed);
        end else if (mem_write) begin
            mem[mem_adr[9:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_adr[9:2]];

    int n_checks = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_iack"}, 32'(i_ack), 0);
        chk({name, "_dack"}, 32'(d_ack), 0);
        chk({name, "_rd"}, 32'(mem_read), 0);
        chk({name, "_wr"}, 32'(mem_write), 0);
        chk({name, "_adr"}, mem_adr, 0);
        chk({name, "_wdat"}, mem_wdata, 0);
        chk({name, "_irdat"}, i_rdata, 0);
        chk({name, "_drdat"}, d_rdata, 0);
    endtask

    task automatic init_mem(input int seed);
        @(negedge clk);
        init_seed = seed;
        init_req  = 1'b1;
        @(negedge clk);
        init_req  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
    endtask

    // Single-requester transaction; ends in IDLE after the ack.
    task automatic txn(input string nm, input bit is_d, input bit we, input logic [31:0] adr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd);
        int lat, rd_p, wr_p;
        bit other;
        logic [31:0] got, adr_seen;
        lat = 0; rd_p = 0; wr_p = 0; other = 0; got = '0; adr_seen = 32'hFFFF_FFFF;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_adr = adr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_adr = adr;
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            rd_p += mem_read ? 1 : 0;
            wr_p += mem_write ? 1 : 0;
            if (mem_read || mem_write) adr_seen = mem_adr;
            if (is_d ? i_ack : d_ack) other = 1'b1;
            if (is_d ? d_ack : i_ack) begin
                lat = c;
                got = is_d ? d_rdata : i_rdata;
                break;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 2);
        chk({nm, "_rdata"}, got, exp_rd);
        chk({nm, "_rd_pulses"}, 32'(rd_p), we ? 0 : 1);
        chk({nm, "_wr_pulses"}, 32'(wr_p), we ? 1 : 0);
        chk({nm, "_other_ack"}, 32'(other), 0);
        chk({nm, "_adr"}, adr_seen, adr);
        @(posedge clk);
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    // Reference model state for the random run.
    logic [31:0] shadow [0:255];
    int          since;
    bit          g_owner;
    bit          g_we;
    logic [31:0] g_adr, g_wdata;
    logic [31:0] exp_i_rd, exp_d_rd;
    int          losses;
    bit          last_d;
    bit          m_i_pend, m_d_pend;

    task automatic rand_cycle();
        bit ir, dr, gd;
        @(posedge clk);
        ir = i_req;
        dr = d_req;
        // Effect of the access that the edge just ended.
        if (since == 0) begin
            if (g_we) shadow[g_adr[9:2]] = g_wdata;
            else if (g_owner) exp_d_rd = shadow[g_adr[9:2]];
            else exp_i_rd = shadow[g_adr[9:2]];
        end
        if ((since < 0 || since >= 2) && (ir || dr)) begin
            if (!ir) gd = 1'b1;
            else if (!dr) gd = 1'b0;
            else begin
`ifdef ARB_ROUND_ROBIN_EN
                gd = !last_d;
`else
                gd = (losses < MAX_WAIT);
`endif
            end
            if (!gd) losses = 0;
            else if (ir) losses = (losses < 15) ? losses + 1 : 15;
            last_d  = gd;
            since   = 0;
            g_owner = gd;
            g_adr   = gd ? d_adr : i_adr;
            g_we    = gd && d_we;
            if (gd) g_wdata = d_wdata;
        end else if (since >= 0 && since < 100) begin
            since++;
        end
        @(negedge clk);
        chk("r_mem_read", 32'(mem_read), 32'(since == 0 && !g_we));
        chk("r_mem_write", 32'(mem_write), 32'(since == 0 && g_we));
        chk("r_i_ack", 32'(i_ack), 32'(since == 1 && !g_owner));
        chk("r_d_ack", 32'(d_ack), 32'(since == 1 && g_owner));
        chk("r_mem_adr", mem_adr, g_adr);
        chk("r_i_rdata", i_rdata, exp_i_rd);
        chk("r_d_rdata", d_rdata, exp_d_rd);
        if (since == 0 && g_we) chk("r_mem_wdata", mem_wdata, g_wdata);
        // Requesters react to the ack the model predicts.
        if (since == 1) begin
            if (g_owner) m_d_pend = 1'b0;
            else m_i_pend = 1'b0;
        end
        if (!m_i_pend && $urandom_range(0, 2) == 0) begin
            m_i_pend = 1'b1;
            i_adr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        end
        if (!m_d_pend && $urandom_range(0, 2) == 0) begin
            m_d_pend = 1'b1;
            d_we = 1'($urandom_range(0, 1));
            d_adr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            d_wdata = $urandom;
        end
        i_req = m_i_pend;
        d_req = m_d_pend;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        bit   exp_order[8];
        int   acks, prev, lc;
        bit   lastd;

        vt[0] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h8C22_0004};
        vt[1] = '{1'b1, 1'b1, 32'h0000_03E8, 32'hDEAD_BEEF, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h0000_03E8, 32'h0, 32'hDEAD_BEEF};
        vt[3] = '{1'b0, 1'b0, 32'h0000_03E8, 32'h0, 32'hDEAD_BEEF};
        vt[4] = '{1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF};
        vt[5] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678};
        vt[6] = '{1'b1, 1'b0, 32'h0000_000B, 32'h0, 32'h8C22_0004};
        vt[7] = '{1'b0, 1'b0, 32'h0000_03EC, 32'h0, 32'h0};

        init_mem(0);
        do_reset();

        // Idle after reset: nothing moves.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_rd", 32'(mem_read), 0);
            chk("idle_wr", 32'(mem_write), 0);
            chk("idle_iack", 32'(i_ack), 0);
            chk("idle_dack", 32'(d_ack), 0);
        end

        for (int v = 0; v < 8; v++) begin
            txn($sformatf("vec%0d", v), vt[v].is_d, vt[v].we, vt[v].adr, vt[v].wdata,
                vt[v].exp_rd);
        end

        // Both requesters held: expected order from the tie rules, starting after an I grant.
        lc = 0;
        lastd = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_order[k] = !lastd;
`else
            exp_order[k] = (lc < MAX_WAIT);
            lc = exp_order[k] ? lc + 1 : 0;
`endif
            lastd = exp_order[k];
        end
        @(negedge clk);
        i_req = 1'b1; i_adr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h10;
        acks = 0;
        prev = -1;
        for (int c = 1; c <= 40 && acks < 8; c++) begin
            @(posedge clk);
            #1;
            if (i_ack || d_ack) begin
                chk("cont_excl", 32'(i_ack && d_ack), 0);
                chk($sformatf("cont_owner%0d", acks), 32'(d_ack), 32'(exp_order[acks]));
                chk("cont_rdata", d_ack ? d_rdata : i_rdata,
                    d_ack ? 32'h1234_5678 : 32'h8C22_0004);
                if (prev >= 0) chk("cont_gap", 32'(c - prev), 3);
                prev = c;
                acks++;
                if (acks == 8) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk("cont_count", 32'(acks), 8);
        @(posedge clk);

        // Reset in the middle of a D write access.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h3EC; d_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        chk("rstmid_wr_before", 32'(mem_write), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("rstmid_now");
        d_req = 1'b0;
        d_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk_all_zero("rstmid_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstmid_no_dack", 32'(d_ack), 0);
        end
        chk("rstmid_nowrite", mem[251], 32'h0);
        txn("rstmid_read", 1'b1, 1'b0, 32'h3EC, 32'h0, 32'h0);

        // Randomized run against the reference model.
        @(negedge clk);
        rst = 1'b1;
        init_mem(1);
        for (int k = 0; k < 256; k++) shadow[k] = mem_pat(k, 1);
        since = -1; g_owner = 1'b0; g_we = 1'b0; g_adr = '0; g_wdata = '0;
        exp_i_rd = '0; exp_d_rd = '0; losses = 0; last_d = 1'b1;
        m_i_pend = 1'b0; m_d_pend = 1'b0;
        do_reset();
        for (int c = 0; c < 600; c++) rand_cycle();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
